// File: rtl/uart_transmit.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Self-contained baud divider; one byte per accepted request.
module uart_transmit #(
  parameter int BAUD_DIV  = 434,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_dout
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(BAUD_DIV - 2);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic             done_q;
  logic             dout_q;

  // The final stop-bit cycle is spent in IDLE with the line still high, so a request
  // accepted in the tx_done cycle starts its start bit with no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      done_q     <= 1'b0;
      dout_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shift_reg <= tx_data;
            if (PARITY != 0)
              parity_bit <= (PARITY == 1) ? ~^tx_data : ^tx_data;
            state    <= S_START;
            dout_q   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
          end
        end
        S_START: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state     <= S_DATA;
            dout_q    <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state  <= S_PARITY;
                dout_q <= parity_bit;
              end else begin
                state  <= S_STOP;
                dout_q <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              dout_q    <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_STOP;
            dout_q   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_idx == STOP_LAST && baud_cnt == CNT_EARLY) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            done_q   <= 1'b1;
          end else if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          dout_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready  = (state == S_IDLE);
  assign tx_busy   = ~tx_ready;
  assign tx_done   = done_q;
  assign uart_dout = dout_q;

endmodule
